// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bus widths and the SRAM responder state type.
package ahb_pkg;

    localparam int AHB_DATA_W = 32;
    localparam int AHB_ADDR_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slave_state_e;

    // True for transfer types that carry an address phase.
    function automatic logic htrans_active(input logic [1:0] trans);
        logic act;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a bus master/interconnect and the SRAM responder.
interface ahb_sram_slave_if import ahb_pkg::*; ();

    logic                  HSEL;
    logic [AHB_ADDR_W-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [AHB_DATA_W-1:0] HWDATA;
    logic                  HREADY;
    logic [AHB_DATA_W-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    // Handshake: an address phase is taken on a rising edge with HSEL && HREADY and an
    // active HTRANS; the data phase ends on the first rising edge where HREADYOUT is 1.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_sram_mem.sv
// Word-wide SRAM array: one synchronous write and one synchronous read per cycle, no reset.
module ahb_sram_mem import ahb_pkg::*; #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  HCLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [AHB_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [AHB_DATA_W-1:0] rdata
);

    logic [AHB_DATA_W-1:0] mem [2**ADDR_WIDTH];

    // Read is old-data on a same-word collision; the parent forwards around it.
    always_ff @(posedge HCLK) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with configurable data-phase wait states.
// Define AHB_SRAM_SLAVE_ERR_EN to build the range/alignment check and two-cycle ERROR response.
module ahb_sram_slave import ahb_pkg::*; #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_sram_slave_if.slave   bus,
    output slave_state_e      fsm_state
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    slave_state_e state, next_state;

    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] word_q;
    logic                  write_q;
    logic                  rd_seen;
    logic                  use_fwd;
    logic [AHB_DATA_W-1:0] fwd_q;
    logic [AHB_DATA_W-1:0] mem_rdata;

    logic [AHB_ADDR_W-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic                  legal;
    logic                  phase_done;
    logic                  acc_ok;
    logic                  we;
    logic                  re;
    logic                  fwd;
    logic                  hready_o;
    logic                  hresp_o;

    assign offset = bus.HADDR - BASE_ADDR;
    assign word   = offset[ADDR_WIDTH+1:2];

`ifdef AHB_SRAM_SLAVE_ERR_EN
    // Below-base addresses wrap to huge offsets and fail the range test too.
    assign legal = (offset[AHB_ADDR_W-1:ADDR_WIDTH+2] == '0) && (bus.HADDR[1:0] == 2'b00);
    logic unused_ok;
    assign unused_ok = ^offset[1:0];
`else
    assign legal = 1'b1;
    logic unused_ok;
    assign unused_ok = ^{offset[AHB_ADDR_W-1:ADDR_WIDTH+2], offset[1:0]};
`endif

    assign acc_ok = phase_done && bus.HSEL && bus.HREADY && htrans_active(bus.HTRANS);
    assign we     = (state == ST_DATA) && (cnt == 4'd0) && write_q;
    assign re     = acc_ok && legal && !bus.HWRITE;
    assign fwd    = we && (word_q == word);

    always_comb begin
        next_state = state;
        hready_o   = 1'b1;
        hresp_o    = HRESP_OKAY;
        phase_done = 1'b0;
        case (state)
            ST_IDLE: phase_done = 1'b1;
            ST_DATA: begin
                hready_o   = (cnt == 4'd0);
                phase_done = (cnt == 4'd0);
            end
`ifdef AHB_SRAM_SLAVE_ERR_EN
            ST_ERR1: begin
                hready_o   = 1'b0;
                hresp_o    = HRESP_ERROR;
                next_state = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o    = HRESP_ERROR;
                phase_done = 1'b1;
            end
`endif
            default: next_state = ST_IDLE;
        endcase
        if (phase_done) begin
            if (acc_ok) next_state = legal ? ST_DATA : ST_ERR1;
            else        next_state = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            word_q  <= '0;
            write_q <= 1'b0;
            rd_seen <= 1'b0;
            use_fwd <= 1'b0;
            fwd_q   <= '0;
        end else begin
            state <= next_state;
            if (acc_ok && legal)                    cnt <= WS;
            else if (state == ST_DATA && cnt != 0)  cnt <= cnt - 4'd1;
            if (acc_ok) begin
                word_q  <= word;
                write_q <= bus.HWRITE && legal;
            end else if (phase_done) begin
                write_q <= 1'b0;
            end
            if (re) begin
                rd_seen <= 1'b1;
                use_fwd <= fwd;
                fwd_q   <= bus.HWDATA;
            end
        end
    end

    ahb_sram_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .HCLK  (HCLK),
        .we    (we),
        .waddr (word_q),
        .wdata (bus.HWDATA),
        .re    (re),
        .raddr (word),
        .rdata (mem_rdata)
    );

    assign bus.HRDATA    = !rd_seen ? '0 : (use_fwd ? fwd_q : mem_rdata);
    assign bus.HREADYOUT = hready_o;
`ifdef AHB_SRAM_SLAVE_ERR_EN
    assign bus.HRESP     = hresp_o;
`else
    assign bus.HRESP     = HRESP_OKAY;
    logic unused_resp;
    assign unused_resp = hresp_o;
`endif
    assign fsm_state     = state;

endmodule
